// File: rtl/accu_diff.sv
`default_nettype none
// ============================================================================
// accu_diff : recovers samples from an accumulated stream (acc[n]-acc[n-1])
//             and buffers them in a small valid/ready output FIFO.
// Revision  : 1.0
// ============================================================================
module accu_diff #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         acc_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNTW-1:0]          sample_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] prev_q,   prev_d;
    logic [WIDTH-1:0] last_q,   last_d;
    logic [CNTW-1:0]  cnt_q,    cnt_d;

    logic             w_accept;
    logic             w_pop;
    logic [WIDTH-1:0] w_prev_eff;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_head;

    assign in_ready   = (count_q < CW'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign w_accept   = in_valid & in_ready;
    assign w_pop      = out_valid & out_ready;
    assign w_prev_eff = clear ? '0 : prev_q;
    assign w_diff     = acc_in - w_prev_eff;
    assign w_head     = mem_q[rd_ptr_q];

    // Once drained, keep presenting the most recently consumed sample.
    assign out_data   = out_valid ? w_head : last_q;
    assign fifo_count = count_q;
    assign sample_cnt = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        prev_d   = prev_q;
        last_d   = last_q;
        cnt_d    = cnt_q;

        if (w_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            prev_d   = acc_in;
            cnt_d    = cnt_q + 1'b1;
        end else if (clear) begin
            prev_d   = '0;
        end

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            last_d   = w_head;
        end

        case ({w_accept, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            prev_q   <= '0;
            last_q   <= '0;
            cnt_q    <= '0;
        end else begin
            if (w_accept) begin
                mem_q[wr_ptr_q] <= w_diff;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            prev_q   <= prev_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accu_diff.sv
`default_nettype none
// ============================================================================
// tb_accu_diff : directed, table-driven bench for accu_diff.
// Revision     : 1.0
// ============================================================================
module tb_accu_diff;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic [7:0] acc_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fifo_count;
    logic [15:0] sample_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    accu_diff #(.WIDTH(8), .DEPTH(4), .CNTW(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .acc_in     (acc_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] acc;
        logic       rdy;
        logic       clr;
        logic       e_ov;
        logic [7:0] e_data;
        logic [2:0] e_cnt;
        logic       e_ir;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, int acc, logic rdy, logic clr,
                                logic ov, int data, int cnt, logic ir);
        vec_t r;
        r.v = v; r.acc = 8'(acc); r.rdy = rdy; r.clr = clr;
        r.e_ov = ov; r.e_data = 8'(data); r.e_cnt = 3'(cnt); r.e_ir = ir;
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic step(logic v, logic [7:0] a, logic rdy, logic clr);
        in_valid  = v;
        acc_in    = a;
        out_ready = rdy;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(int idx);
        vec_t r;
        r = tbl[idx];
        step(r.v, r.acc, r.rdy, r.clr);
        n_tests++;
        if (out_valid !== r.e_ov || (r.e_ov && out_data !== r.e_data) ||
            (!r.e_ov && out_data !== r.e_data) ||
            fifo_count !== r.e_cnt || in_ready !== r.e_ir) begin
            n_fail++;
            $display("FAIL row%0d: got ov=%0b data=%0d cnt=%0d ir=%0b, expected ov=%0b data=%0d cnt=%0d ir=%0b",
                     idx, out_valid, out_data, fifo_count, in_ready,
                     r.e_ov, r.e_data, r.e_cnt, r.e_ir);
        end
    endtask

    initial begin
        // basic decode (rows 0..5)
        tbl.push_back(mk(1,   0, 1, 0, 1,   0, 1, 1));
        tbl.push_back(mk(1,   1, 1, 0, 1,   1, 1, 1));
        tbl.push_back(mk(1,   3, 1, 0, 1,   2, 1, 1));
        tbl.push_back(mk(1,   6, 1, 0, 1,   3, 1, 1));
        tbl.push_back(mk(1,  10, 1, 0, 1,   4, 1, 1));
        tbl.push_back(mk(0,   0, 1, 0, 0,   4, 0, 1));
        // wrap-around, restarted from zero with a clear on the first sample
        tbl.push_back(mk(1, 250, 1, 1, 1, 250, 1, 1));
        tbl.push_back(mk(1,   4, 1, 0, 1,  10, 1, 1));
        tbl.push_back(mk(1,   4, 1, 0, 1,   0, 1, 1));
        tbl.push_back(mk(0,   0, 1, 0, 0,   0, 0, 1));
        // backpressure, full, pop-while-full, simultaneous accept/pop at 2
        tbl.push_back(mk(1,  10, 0, 0, 1,   6, 1, 1));
        tbl.push_back(mk(1,  30, 0, 0, 1,   6, 2, 1));
        tbl.push_back(mk(1,  60, 0, 0, 1,   6, 3, 1));
        tbl.push_back(mk(1, 100, 0, 0, 1,   6, 4, 0));
        tbl.push_back(mk(1, 150, 0, 0, 1,   6, 4, 0));
        tbl.push_back(mk(1, 150, 1, 0, 1,  20, 3, 1));
        tbl.push_back(mk(1, 150, 0, 0, 1,  20, 4, 0));
        tbl.push_back(mk(0,   0, 1, 0, 1,  30, 3, 1));
        tbl.push_back(mk(0,   0, 1, 0, 1,  40, 2, 1));
        tbl.push_back(mk(1, 160, 1, 0, 1,  50, 2, 1));
        tbl.push_back(mk(1, 165, 1, 0, 1,  10, 2, 1));
        tbl.push_back(mk(0,   0, 1, 0, 1,   5, 1, 1));
        tbl.push_back(mk(0,   0, 1, 0, 0,   5, 0, 1));
        // clear alone, then clear together with an accept
        tbl.push_back(mk(1, 100, 1, 0, 1, 191, 1, 1));
        tbl.push_back(mk(0,   0, 1, 1, 0, 191, 0, 1));
        tbl.push_back(mk(1, 120, 1, 0, 1, 120, 1, 1));
        tbl.push_back(mk(1,  30, 1, 0, 1, 166, 1, 1));
        tbl.push_back(mk(1,  50, 1, 1, 1,  50, 1, 1));
        tbl.push_back(mk(1,  55, 1, 0, 1,   5, 1, 1));
        tbl.push_back(mk(0,   0, 1, 0, 0,   5, 0, 1));

        in_valid = 0; acc_in = 0; out_ready = 0; clear = 0;
        reset = 0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_out_data", int'(out_data), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1;

        for (int i = 0; i < 6; i++) run_row(i);
        chk("sample_cnt_basic", int'(sample_cnt), 5);
        for (int i = 6; i < tbl.size(); i++) run_row(i);
        chk("sample_cnt_total", int'(sample_cnt), 20);

        // asynchronous reset with three samples buffered
        step(1, 8'd11, 0, 0);
        step(1, 8'd12, 0, 0);
        step(1, 8'd13, 0, 0);
        chk("pre_rst_count", int'(fifo_count), 3);
        in_valid = 0;
        #3 reset = 0;
        #1;
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_fifo_count", int'(fifo_count), 0);
        chk("async_sample_cnt", int'(sample_cnt), 0);
        chk("async_out_data", int'(out_data), 0);
        chk("async_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #3 reset = 1;
        @(posedge clk);
        #1;
        step(1, 8'd7, 0, 0);
        chk("post_rst_valid", int'(out_valid), 1);
        chk("post_rst_data", int'(out_data), 7);
        chk("post_rst_sample_cnt", int'(sample_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/accu_diff.md
Name: accu_diff

Overview:
- Inverse of the running accumulator: receives the stream of accumulated values and recovers the original input samples as modulo-2^WIDTH differences, out = acc[n] - acc[n-1].
- Sits at the receive end of an accumulate/transport link.
- Buffers recovered samples in a small output FIFO with valid/ready handshakes on both sides.
- Provides a synchronous clear that mirrors an accumulator reset mid-stream.

Parameters:
- WIDTH, 8, data width of accumulated input and recovered output.
- DEPTH, 4, output FIFO entries; power of two, >= 2.
- CNTW, 16, width of accepted-sample counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous; previous-value register returns to 0, as the accumulator does on its reset.
- acc_in  input  WIDTH  accumulated value from upstream.
- in_valid  input  1  acc_in is valid.
- in_ready  output  1  block can accept acc_in this cycle.
- out_data  output  WIDTH  recovered sample at FIFO head.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream consumes the head this cycle.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- sample_cnt  output  CNTW  number of accepted inputs since reset.

Behaviour:
- Reset (reset low, asynchronous):
  - prev, fifo_count, sample_cnt and the read/write pointers go to 0.
  - out_valid goes to 0 and in_ready goes to 1.
  - out_data is 0.
  - All of these hold while reset is low.
- Handshake terms:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (fifo_count < DEPTH). It is registered-state based, with no same-cycle pass-through from pop.
- Difference:
  - diff = (acc_in - prev_eff) mod 2^WIDTH.
  - prev_eff = 0 if clear is high in the same cycle, otherwise prev.
  - Wrap-around is natural two's-complement truncation. Example: prev = 250, acc_in = 4 -> diff = 10.
- On accept:
  - diff is written to the FIFO.
  - prev <= acc_in.
  - sample_cnt increments, wrapping at 2^CNTW.
- clear without accept: prev <= 0. sample_cnt and FIFO contents are untouched.
- clear with accept: diff is taken against 0 and prev <= acc_in.
- Latency: a sample accepted at edge k is visible on out_data/out_valid in cycle k+1 if the FIFO was empty. There is no combinational input->output path.
- Output: out_data always shows the FIFO head; it is don't-care-free and holds its last value when empty. out_valid = (fifo_count != 0).
- Simultaneous accept and pop: fifo_count is unchanged; both pointers advance.
- Full (fifo_count == DEPTH):
  - in_ready = 0; inputs stall, nothing is dropped, and prev is not updated.
  - A pop while full raises in_ready on the next cycle.
- Empty: a pop cannot occur because out_valid = 0; out_ready is ignored.
- Pointers wrap modulo DEPTH.
- in_valid with in_ready low: no state change; upstream holds acc_in.
- Reset mid-operation: all buffered samples are discarded. The first accept after reset returns acc_in - 0.
- The state machine is implicit in the occupancy:
  - EMPTY (count 0): in_ready = 1, out_valid = 0.
  - PARTIAL: in_ready = 1, out_valid = 1.
  - FULL (count DEPTH): in_ready = 0, out_valid = 1.
- Occupancy transitions:
  - +1 on accept without pop.
  - -1 on pop without accept.
  - Unchanged otherwise.

Test Plan:
- Basic decode: out_ready = 1; feed acc_in 0,1,3,6,10 (accumulated 0..4) one per cycle -> out_data 0,1,2,3,4, each one cycle after accept; sample_cnt = 5.
- Wrap-around: feed 250 then 4 then 4 -> outputs 250, 10, 0.
- Backpressure/full: out_ready = 0; feed 5 inputs -> first 4 accepted, fifo_count = 4, in_ready = 0 and the 5th held. Raise out_ready for 1 cycle -> pop one entry, in_ready = 1 the next cycle, and the 5th is accepted with the correct diff.
- Simultaneous accept and pop at count = 2 -> count stays 2 and order is preserved (FIFO order check against a model).
- Clear: after accepting 100, pulse clear alone, then feed 120 -> output 120. Also drive clear and accept of 50 in the same cycle after prev = 30 -> output 50, and prev = 50 afterwards.
- Asynchronous reset mid-stream:
  - Setup: 3 entries buffered.
  - Drop reset between clock edges -> out_valid = 0, fifo_count = 0 and sample_cnt = 0 immediately.
  - After release, feed 7 -> output 7.
